// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// It runs one transfer at a time, rejects sel==0 requests and aborts transfers whose wait runs out.
module apb_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ*8-1:0]      req_wait_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      busy_o,
    output logic                      m_start_o,
    output logic                      m_write_o,
    output logic [SEL_W-1:0]          m_sel_o,
    output logic [ADDR_W-1:0]         m_addr_o,
    output logic [DATA_W-1:0]         m_wdata_o,
    output logic [7:0]                m_wait_cycles_o,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic                      m_ready_i
);

    // state | meaning
    // IDLE  | no owner; arbitrate among pending requests
    // ISSUE | payload on m_*, m_start pulsed for this cycle
    // WAIT  | waiting for m_ready, timeout counter running
    // DONE  | done pulse to owner, pointer advances
    // ERR   | err pulse to owner (illegal sel or timeout), pointer advances
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic                m_start_q, m_start_d;
    logic                m_write_q, m_write_d;
    logic [SEL_W-1:0]    m_sel_q, m_sel_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [7:0]          m_wait_q, m_wait_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [SEL_W-1:0]    win_sel;

    // First pending request at or after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        win_sel = req_sel_i[int'(win_idx)*SEL_W +: SEL_W];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        rsp_rdata_d = rsp_rdata_q;
        m_start_d   = 1'b0;
        m_write_d   = m_write_q;
        m_sel_d     = m_sel_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_wait_d    = m_wait_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d          = win_idx;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    m_write_d        = req_write_i[win_idx];
                    m_sel_d          = win_sel;
                    m_addr_d         = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                    m_wdata_d        = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                    m_wait_d         = req_wait_i[int'(win_idx)*8 +: 8];
                    if (win_sel == '0) begin
                        state_d        = S_ERR;
                        err_d[win_idx] = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        m_start_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A ready arriving on the last allowed cycle still completes the transfer.
                if (m_ready_i) begin
                    state_d         = S_DONE;
                    done_d[owner_q] = 1'b1;
                    if (!m_write_q) rsp_rdata_d = m_rdata_i;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d        = S_ERR;
                    err_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            m_start_q   <= 1'b0;
            m_write_q   <= 1'b0;
            m_sel_q     <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wait_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            m_start_q   <= m_start_d;
            m_write_q   <= m_write_d;
            m_sel_q     <= m_sel_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wait_q    <= m_wait_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign busy_o          = busy_q;
    assign m_start_o       = m_start_q;
    assign m_write_o       = m_write_q;
    assign m_sel_o         = m_sel_q;
    assign m_addr_o        = m_addr_q;
    assign m_wdata_o       = m_wdata_q;
    assign m_wait_cycles_o = m_wait_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Bench for apb_request_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of round-robin arbitration, completion and timeout.
module tb_apb_request_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0, req_write = '0;
    logic [7:0]  req_sel = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_wait = '0;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rsp_rdata;
    logic        busy, m_start, m_write;
    logic [1:0]  m_sel;
    logic [7:0]  m_addr, m_wdata, m_wait;
    logic [7:0]  m_rdata = '0;
    logic        m_ready = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    int          ptr = 0;
    logic [7:0]  last_rdata = '0;

    apb_request_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .ADDR_W(8), .SEL_W(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_i(req), .req_write_i(req_write), .req_sel_i(req_sel),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wait_i(req_wait),
        .gnt_o(gnt), .done_o(done), .err_o(err), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
        .m_start_o(m_start), .m_write_o(m_write), .m_sel_o(m_sel), .m_addr_o(m_addr),
        .m_wdata_o(m_wdata), .m_wait_cycles_o(m_wait),
        .m_rdata_i(m_rdata), .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [1:0] sel,
                           input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] wc);
        req[i]             = 1'b1;
        req_write[i]       = wr;
        req_sel[i*2 +: 2]  = sel;
        req_addr[i*8 +: 8] = addr;
        req_wdata[i*8 +: 8] = wd;
        req_wait[i*8 +: 8] = wc;
    endtask

    task automatic raise_random(input int i, input bit legal);
        logic [1:0] s;
        s = legal ? 2'(1 + $urandom_range(0, 2)) : 2'($urandom_range(0, 3));
        set_req(i, 1'($urandom_range(0, 1)), s, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Round-robin choice: first pending requester at or after the pointer.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Runs one transfer from an IDLE cycle with at least one req pending.
    // d: WAIT cycle on which ready is given (> TIMEOUT means never).
    task automatic do_txn(input int d, input bit hold, input logic [7:0] rd,
                          input bit early, input bit churn);
        int         w, c;
        bit         fin;
        logic [1:0] e_sel;
        logic [7:0] e_addr, e_wdata, e_wait;
        logic       e_wr;
        w = pick(req, ptr);
        if (w < 0) begin
            check("txn_no_request", 32'(req), 32'hF);
            return;
        end
        e_sel = req_sel[w*2 +: 2];  e_addr = req_addr[w*8 +: 8];
        e_wdata = req_wdata[w*8 +: 8];  e_wait = req_wait[w*8 +: 8];  e_wr = req_write[w];
        m_ready = early;
        m_rdata = rd;
        step();
        check("gnt_issue", 32'(gnt), 32'(1 << w));
        check("m_sel", 32'(m_sel), 32'(e_sel));
        check("m_addr", 32'(m_addr), 32'(e_addr));
        check("m_wdata", 32'(m_wdata), 32'(e_wdata));
        check("m_wait", 32'(m_wait), 32'(e_wait));
        check("m_write", 32'(m_write), 32'(e_wr));
        check("busy_issue", 32'(busy), 32'd1);
        if (e_sel == 2'd0) begin
            check("m_start_illegal", 32'(m_start), 32'd0);
            check("err_illegal", 32'(err), 32'(1 << w));
            check("done_illegal", 32'(done), 32'd0);
        end else begin
            check("m_start_issue", 32'(m_start), 32'd1);
            check("done_issue", 32'(done | err), 32'd0);
            step();
            check("m_start_wait", 32'(m_start), 32'd0);
            check("done_wait0", 32'(done | err), 32'd0);
            c = 0;
            fin = 0;
            while (!fin) begin
                c++;
                m_ready = (c == d);
                if (churn && $urandom_range(0, 2) == 0) begin
                    int j = $urandom_range(0, 3);
                    if (j != w && !req[j]) raise_random(j, 1'b0);
                end
                step();
                if (c == d) begin
                    fin = 1;
                    check("done_pulse", 32'(done), 32'(1 << w));
                    check("err_on_done", 32'(err), 32'd0);
                    if (!e_wr) last_rdata = rd;
                end else if (c == TIMEOUT) begin
                    fin = 1;
                    check("err_timeout", 32'(err), 32'(1 << w));
                    check("done_on_timeout", 32'(done), 32'd0);
                end else begin
                    check("wait_quiet", 32'(done | err | 4'(m_start)), 32'd0);
                    check("m_addr_stable", 32'(m_addr), 32'(e_addr));
                end
            end
            m_ready = 1'b0;
        end
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        check("gnt_final", 32'(gnt), 32'(1 << w));
        ptr = (w + 1) % 4;
        if (!hold) req[w] = 1'b0;
        step();
        check("idle_gap", 32'({gnt, done, err, busy, m_start}), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        check("rst_outputs", 32'({gnt, done, err, busy, m_start, m_write}), 32'd0);
        check("rst_payload", {m_sel, m_addr, m_wdata, m_wait[5:0]}, 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        step();
        reset = 1'b0;

        // Fairness: all four held, grants rotate 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'(1 + i % 3), 8'(8'h20 + i), 8'(i), 8'd1);
        for (int t = 0; t < 5; t++) do_txn(1, 1'b1, 8'(8'hC0 + t), 1'b0, 1'b0);
        req = '0;
        step();

        // Single read from requester 1, ready on the second WAIT cycle
        set_req(1, 1'b0, 2'd2, 8'h10, 8'h00, 8'd2);
        do_txn(2, 1'b0, 8'hA5, 1'b0, 1'b0);

        // Illegal select, then pointer must sit on 3
        set_req(2, 1'b0, 2'd0, 8'h44, 8'h00, 8'd0);
        do_txn(1, 1'b0, 8'h11, 1'b0, 1'b0);
        set_req(0, 1'b0, 2'd1, 8'h50, 8'h00, 8'd0);
        set_req(3, 1'b1, 2'd3, 8'h53, 8'h77, 8'd0);
        do_txn(1, 1'b0, 8'h22, 1'b0, 1'b0);

        // Timeout on requester 0, then normal arbitration resumes
        do_txn(TIMEOUT + 1, 1'b0, 8'h33, 1'b0, 1'b0);
        set_req(1, 1'b0, 2'd1, 8'h61, 8'h00, 8'd3);
        do_txn(3, 1'b0, 8'h5C, 1'b0, 1'b0);

        // Ready on the same cycle the timeout would fire
        set_req(2, 1'b0, 2'd1, 8'h62, 8'h00, 8'd4);
        do_txn(TIMEOUT, 1'b0, 8'h5A, 1'b0, 1'b0);

        // Ready held high through IDLE and ISSUE must be ignored there
        set_req(3, 1'b0, 2'd2, 8'h63, 8'h00, 8'd2);
        do_txn(2, 1'b0, 8'h6B, 1'b1, 1'b0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 1) == 1) raise_random(i, 1'b0);
            if (req == '0) raise_random($urandom_range(0, 3), 1'b0);
            do_txn($urandom_range(1, TIMEOUT + 2), 1'b0, 8'($urandom), 1'b0, 1'b1);
        end
        req = '0;
        step();

        // Asynchronous reset in the middle of WAIT
        set_req(2, 1'b0, 2'd1, 8'h3C, 8'h00, 8'd9);
        step();
        step();
        step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ctl", 32'({gnt, done, err, busy, m_start, m_write}), 32'd0);
        check("async_rst_payload", {m_sel, m_addr, m_wdata, m_wait[5:0]}, 32'd0);
        check("async_rst_rdata", 32'(rsp_rdata), 32'd0);
        req = '0;
        step();
        reset = 1'b0;
        ptr = 0;
        last_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_quiet", 32'({done, err, busy}), 32'd0);
        end
        for (int i = 0; i < 4; i++) raise_random(i, 1'b1);
        do_txn(1, 1'b0, 8'h9E, 1'b0, 1'b0);
        do_txn(2, 1'b0, 8'h9F, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
